// File: rtl/ifetch_queue.sv
// ifetch_queue: instruction fetch/prefetch stage.
// Fetches 32-bit words over a req/ack handshake, splits each into two
// 16-bit parcels tagged with their PC and buffers them in a small FIFO
// feeding the decoder. A redirect flushes the queue and restarts fetch.
module ifetch_queue #(
   parameter int unsigned DEPTH    = 4,
   parameter logic [31:0] RESET_PC = 32'd0
) (
   input  logic        i_clk,
   input  logic        i_rst,
   output logic        o_mem_req,
   output logic [31:0] o_mem_addr,
   input  logic        i_mem_ack,
   input  logic [31:0] i_mem_data,
   input  logic        i_redirect,
   input  logic [31:0] i_redirect_pc,
   output logic        o_valid,
   output logic [15:0] o_ir,
   output logic [31:0] o_pc,
   input  logic        i_ready
);

   localparam int unsigned PW = $clog2(DEPTH);
   localparam int unsigned CW = PW + 1;

   typedef enum logic [1:0] {
      S_IDLE,
      S_REQ,
      S_DROP
   } state_t;

   state_t        r_state;
   logic [31:0]   r_fpc;
   logic [31:0]   r_mem_addr;
   logic          r_mem_req;
   logic [CW-1:0] r_count;
   logic [PW-1:0] r_rd;
   logic [PW-1:0] r_wr;
   logic [15:0]   r_ir [DEPTH];
   logic [31:0]   r_pc [DEPTH];

   logic [CW-1:0] w_need;
   logic [CW-1:0] w_free;
   logic [CW-1:0] w_npush;
   logic [PW-1:0] w_wr_hi;
   logic [31:0]   w_fetch_addr;
   logic [31:0]   w_redirect_pc;
   logic          w_pop;
   logic          w_ack;
   logic          w_push_lo;

   // A fetch starting at an odd halfword only yields the upper parcel,
   // so only one slot has to be free for it.
   assign w_need        = r_fpc[1] ? CW'(1) : CW'(2);
   assign w_free        = CW'(DEPTH) - r_count;
   assign w_fetch_addr  = r_fpc & 32'hFFFF_FFFC;
   assign w_redirect_pc = i_redirect_pc & 32'hFFFF_FFFE;

   // A redirect voids both the pop and the push of its cycle.
   assign w_pop     = (r_count != '0) && i_ready && !i_redirect;
   assign w_ack     = (r_state == S_REQ) && i_mem_ack && !i_redirect;
   assign w_push_lo = w_ack && !r_fpc[1];
   assign w_npush   = CW'(w_push_lo) + CW'(w_ack);
   assign w_wr_hi   = r_wr + PW'(w_push_lo);

   assign o_mem_req  = r_mem_req;
   assign o_mem_addr = r_mem_addr;
   assign o_valid    = (r_count != '0);
   assign o_ir       = r_ir[r_rd];
   assign o_pc       = r_pc[r_rd];

   // Fetch FSM, fetch pointer and FIFO pointers/occupancy.
   always_ff @(posedge i_clk) begin
      // NOTE: all sequential state uses non-blocking assignments so every
      // register samples the pre-edge values regardless of statement order.
      if (i_rst) begin
         r_state    <= S_IDLE;
         r_fpc      <= RESET_PC;
         r_count    <= '0;
         r_rd       <= '0;
         r_wr       <= '0;
         r_mem_req  <= 1'b0;
         r_mem_addr <= '0;
      end else if (i_redirect) begin
         r_fpc   <= w_redirect_pc;
         r_count <= '0;
         r_rd    <= '0;
         r_wr    <= '0;
         // An outstanding request cannot be withdrawn; if it has not been
         // acked yet, wait for its ack in DROP and discard the data.
         case (r_state)
            S_REQ, S_DROP: begin
               if (i_mem_ack) begin
                  r_state   <= S_IDLE;
                  r_mem_req <= 1'b0;
               end else begin
                  r_state <= S_DROP;
               end
            end
            default: ;
         endcase
      end else begin
         r_count <= r_count + w_npush - CW'(w_pop);
         r_rd    <= r_rd + PW'(w_pop);
         r_wr    <= r_wr + PW'(w_npush);
         case (r_state)
            S_IDLE: begin
               // Space is reserved here; later pops only add room, so the
               // push on ack can never overflow.
               if (w_free >= w_need) begin
                  r_state    <= S_REQ;
                  r_mem_req  <= 1'b1;
                  r_mem_addr <= w_fetch_addr;
               end
            end
            S_REQ: begin
               if (i_mem_ack) begin
                  r_state   <= S_IDLE;
                  r_mem_req <= 1'b0;
                  r_fpc     <= r_mem_addr + 32'd4;
               end
            end
            S_DROP: begin
               if (i_mem_ack) begin
                  r_state   <= S_IDLE;
                  r_mem_req <= 1'b0;
               end
            end
            default: r_state <= S_IDLE;
         endcase
      end
   end

   // Parcel storage: lower parcel (if wanted) then upper parcel on ack.
   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         // NOTE: the storage is cleared on reset so the head outputs read
         // as zero afterwards; this costs a reset on every storage flop.
         for (int i = 0; i < int'(DEPTH); i++) begin
            r_ir[i] <= '0;
            r_pc[i] <= '0;
         end
      end else begin
         if (w_push_lo) begin
            r_ir[r_wr] <= i_mem_data[15:0];
            r_pc[r_wr] <= r_mem_addr;
         end
         if (w_ack) begin
            r_ir[w_wr_hi] <= i_mem_data[31:16];
            r_pc[w_wr_hi] <= r_mem_addr + 32'd2;
         end
      end
   end

endmodule

// File: tb/tb_ifetch_queue.sv
// tb_ifetch_queue: scoreboard bench for ifetch_queue.
// The reference model is the program-order parcel stream: after a reset
// or redirect to pc P, the consumer must see P, P+2, P+4, ... with each
// parcel taken from the memory image, until the next reset or redirect.
module tb_ifetch_queue;

   typedef struct {
      logic [31:0] pc;
      logic [15:0] ir;
   } exp_t;

   logic        clk;
   logic        i_rst;
   logic        o_mem_req;
   logic [31:0] o_mem_addr;
   logic        i_mem_ack;
   logic [31:0] i_mem_data;
   logic        i_redirect;
   logic [31:0] i_redirect_pc;
   logic        o_valid;
   logic [15:0] o_ir;
   logic [31:0] o_pc;
   logic        i_ready;

   int   n_checks = 0;
   int   n_errors = 0;
   int   n_pops   = 0;
   int   mem_wait = 0;   // fixed ack latency; negative means random 0..3
   int   mem_cnt  = 0;
   int   mem_lat  = 0;
   exp_t exp_q[$];

   ifetch_queue #(.DEPTH(4), .RESET_PC(32'd0)) dut (
      .i_clk         (clk),
      .i_rst         (i_rst),
      .o_mem_req     (o_mem_req),
      .o_mem_addr    (o_mem_addr),
      .i_mem_ack     (i_mem_ack),
      .i_mem_data    (i_mem_data),
      .i_redirect    (i_redirect),
      .i_redirect_pc (i_redirect_pc),
      .o_valid       (o_valid),
      .o_ir          (o_ir),
      .o_pc          (o_pc),
      .i_ready       (i_ready)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      if (a == 32'd0) return 32'h2222_1111;
      if (a == 32'd4) return 32'h4444_3333;
      return {a[15:0] ^ 16'h5A5A, a[15:0] ^ 16'hA5A5};
   endfunction

   function automatic logic [15:0] parcel_at(input logic [31:0] pc);
      logic [31:0] w;
      w = mem_word({pc[31:2], 2'b00});
      return pc[1] ? w[31:16] : w[15:0];
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // New program-order epoch starting at start_pc.
   task automatic fill_expected(input logic [31:0] start_pc);
      logic [31:0] p;
      exp_t e;
      exp_q.delete();
      p = start_pc & 32'hFFFF_FFFE;
      for (int i = 0; i < 1024; i++) begin
         e.pc = p;
         e.ir = parcel_at(p);
         exp_q.push_back(e);
         p = p + 32'd2;
      end
   endtask

   task automatic do_reset(input int cycles);
      i_rst = 1'b1;
      fill_expected(32'd0);
      repeat (cycles) @(posedge clk);
      #1;
      i_rst = 1'b0;
   endtask

   task automatic do_redirect(input logic [31:0] pc);
      i_redirect    = 1'b1;
      i_redirect_pc = pc;
      fill_expected(pc);
      @(posedge clk);
      #1;
      i_redirect = 1'b0;
   endtask

   task automatic wait_req_rise(output logic [31:0] addr, output bit ok);
      logic prev;
      prev = o_mem_req;
      ok   = 1'b0;
      addr = '0;
      for (int i = 0; i < 60 && !ok; i++) begin
         @(posedge clk);
         #1;
         if (o_mem_req && !prev) begin
            ok   = 1'b1;
            addr = o_mem_addr;
         end
         prev = o_mem_req;
      end
   endtask

   task automatic expect_req(input string name, input logic [31:0] exp_addr);
      logic [31:0] a;
      bit ok;
      wait_req_rise(a, ok);
      if (ok) check(name, a, exp_addr);
      else check({name, "_timeout"}, 32'd0, 32'd1);
   endtask

   task automatic wait_pops(input string name, input int n);
      int target;
      target = n_pops + n;
      for (int i = 0; i < 200 && n_pops < target; i++) begin
         @(posedge clk);
         #1;
      end
      check(name, 32'(n_pops >= target), 32'd1);
   endtask

   // Memory model: acks after mem_lat wait cycles, junk data otherwise.
   always @(posedge clk) begin
      #1;
      if (o_mem_req) begin
         if (mem_cnt == 0) mem_lat = (mem_wait < 0) ? int'($urandom_range(0, 3)) : mem_wait;
         i_mem_ack  = (mem_cnt >= mem_lat);
         i_mem_data = i_mem_ack ? mem_word(o_mem_addr) : $urandom;
         mem_cnt++;
      end else begin
         i_mem_ack  = 1'b0;
         i_mem_data = $urandom;
         mem_cnt    = 0;
      end
   end

   // Monitor: pops the scoreboard on every accepted parcel and watches
   // the memory handshake and post-redirect behaviour.
   logic        redir_d = 1'b0;
   logic        req_d   = 1'b0;
   logic        ack_d   = 1'b0;
   logic [31:0] addr_d  = '0;

   always @(negedge clk) begin
      exp_t e;
      if (i_rst) begin
         redir_d = 1'b0;
         req_d   = 1'b0;
         ack_d   = 1'b0;
      end else begin
         if (redir_d) check("valid_after_redirect", 32'(o_valid), 32'd0);
         if (o_mem_req) check("addr_aligned", 32'(o_mem_addr[1:0]), 32'd0);
         if (req_d && !ack_d && o_mem_req) check("addr_stable", o_mem_addr, addr_d);
         if (o_valid && i_ready && !i_redirect) begin
            if (exp_q.size() == 0) begin
               check("scoreboard_empty", 32'd1, 32'd0);
            end else begin
               e = exp_q.pop_front();
               check("pop_pc", o_pc, e.pc);
               check("pop_ir", 32'(o_ir), 32'(e.ir));
               n_pops++;
            end
         end
         redir_d = i_redirect;
         req_d   = o_mem_req;
         ack_d   = i_mem_ack;
         addr_d  = o_mem_addr;
      end
   end

   initial begin
      logic [31:0] a;
      bit ok;
      int pops_before;
      i_rst         = 1'b1;
      i_redirect    = 1'b0;
      i_redirect_pc = '0;
      i_ready       = 1'b0;
      i_mem_ack     = 1'b0;
      i_mem_data    = '0;
      fill_expected(32'd0);
      repeat (2) @(posedge clk);
      @(negedge clk);
      check("rst_mem_req", 32'(o_mem_req), 32'd0);
      check("rst_mem_addr", o_mem_addr, 32'd0);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_ir", 32'(o_ir), 32'd0);
      check("rst_pc", o_pc, 32'd0);
      @(posedge clk);
      #1;

      // 1: zero-wait streaming from reset.
      i_ready  = 1'b1;
      mem_wait = 0;
      i_rst    = 1'b0;
      wait_pops("t1_pops", 4);

      // 2: consumer stalled until the queue is full, then released.
      i_ready = 1'b0;
      do_reset(1);
      repeat (12) @(posedge clk);
      #1;
      check("t2_req_idle", 32'(o_mem_req), 32'd0);
      check("t2_valid", 32'(o_valid), 32'd1);
      check("t2_head_ir", 32'(o_ir), 32'h1111);
      check("t2_head_pc", o_pc, 32'd0);
      i_ready = 1'b1;
      expect_req("t2_resume_addr", 32'd8);

      // 3: redirect to an odd halfword.
      do_redirect(32'h102);
      expect_req("t3_addr", 32'h100);
      expect_req("t3_next_addr", 32'h104);
      wait_pops("t3_pops", 2);

      // 4: redirect while a slow request is outstanding.
      mem_wait = 3;
      wait_req_rise(a, ok);
      check("t4_req_seen", 32'(ok), 32'd1);
      do_redirect(32'h40);
      check("t4_drop_req", 32'(o_mem_req), 32'd1);
      check("t4_drop_addr", o_mem_addr, a);
      expect_req("t4_new_addr", 32'h40);
      wait_pops("t4_pops", 2);

      // 5: redirect, ack and pop in the same cycle.
      mem_wait = 0;
      ok = 1'b0;
      for (int i = 0; i < 40 && !ok; i++) begin
         @(posedge clk);
         #1;
         ok = o_mem_req && o_valid;
      end
      check("t5_setup", 32'(ok), 32'd1);
      do_redirect(32'h200);
      wait_pops("t5_pops", 2);

      // 6: one-cycle reset in the middle of a request.
      mem_wait = 3;
      wait_req_rise(a, ok);
      check("t6_req_seen", 32'(ok), 32'd1);
      do_reset(1);
      check("t6_req_dropped", 32'(o_mem_req), 32'd0);
      check("t6_valid", 32'(o_valid), 32'd0);
      expect_req("t6_restart_addr", 32'd0);

      // Random phase: random stalls, latencies and redirects.
      mem_wait    = -1;
      pops_before = n_pops;
      for (int i = 0; i < 400; i++) begin
         @(posedge clk);
         #1;
         i_ready = ($urandom_range(0, 9) < 7);
         if ($urandom_range(0, 24) == 0) do_redirect($urandom & 32'h0000_0FFF);
      end
      i_ready = 1'b1;
      wait_pops("rand_drain", 4);
      check("rand_progress", 32'(n_pops - pops_before >= 50), 32'd1);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

   initial begin
      #200000;
      $display("FAIL watchdog: got timeout expected finish");
      $fatal(1, "watchdog");
   end

endmodule
